pe_seq_ctrl: RTL and testbench
==============================

PE_SEQ_CTRL -- requirements
Module: pe_seq_ctrl

Interface
REQ-001 The module SHALL have exactly one clock; reset SHALL be asynchronous and active-low.
REQ-002 Port `clk`, input, 1 bit: rising-edge clock.
REQ-003 Port `rst_n`, input, 1 bit: asynchronous active-low reset.
REQ-004 Port `start`, input, 1 bit: begin a dot-product job; sampled only in IDLE.
REQ-005 Port `mode`, input, 2 bits: precision mode, sampled with `start`.
  - 00 = 2x2
  - 01 = 4x4
  - 10 = 8x8
  - 11 = 16x8, two beats per element
REQ-006 Port `len`, input, 8 bits: number of elements to accumulate, sampled with `start`.
REQ-007 Port `abort`, input, 1 bit: synchronous job cancel.
REQ-008 Port `in_valid`, input, 1 bit: operand beat present at the PE adder inputs.
REQ-009 Port `in_ready`, output, 1 bit: controller accepts the beat this cycle.
REQ-010 Port `pe_sum`, input, 20 bits: combinational result returned by the PE adder.
REQ-011 Port `sum_signal_1` .. `sum_signal_4`, output, 2 bits each: per-group shift codes, in units of 4 bits, driven to the adder.
REQ-012 Port `previous_sum`, output, 20 bits: accumulator fed back to the adder.
REQ-013 Port `out_valid`, output, 1 bit: result available.
REQ-014 Port `out_ready`, input, 1 bit: consumer accepts the result.
REQ-015 Port `out_data`, output, 20 bits: final accumulated sum.
REQ-016 Port `busy`, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-017 The FSM SHALL have three states: IDLE, RUN and OUT.
REQ-018 In IDLE, when `start`=1 the block SHALL:
  - latch `mode`;
  - latch `len`, with `len`=0 treated as 1;
  - clear the accumulator, element counter and phase;
  - enter RUN on the next edge.
REQ-019 `start` SHALL be ignored outside IDLE.
REQ-020 In RUN, `in_ready` SHALL be 1; in IDLE and OUT it SHALL be 0.
REQ-021 A beat SHALL be accepted when `in_valid` and `in_ready` are both 1.
REQ-022 On each accepted beat, the accumulator SHALL load `pe_sum`.
  - Accumulation wraps modulo 2^20; no saturation and no overflow flag.
REQ-023 `previous_sum` SHALL equal the accumulator register in every state.
REQ-024 Shift codes SHALL be combinational from state, latched mode and phase, in order {sum_signal_1, _2, _3, _4}:
  - mode 00 or 01: {0,0,0,0};
  - mode 10: {0,1,1,2};
  - mode 11, phase 0: {0,1,1,2};
  - mode 11, phase 1: {1,2,2,3};
  - IDLE and OUT: {0,0,0,0}.
REQ-025 In modes 00, 01 and 10, every accepted beat SHALL increment the element counter.
REQ-026 In mode 11, an accepted beat SHALL toggle the phase.
  - The element counter SHALL increment only on a phase-1 beat.
REQ-027 The beat that completes element number `len` SHALL move the FSM to RUN -> OUT on that edge.
  - `out_valid` rises the cycle after the last beat is accepted (latency 1).
REQ-028 A cycle with `in_valid`=0 in RUN SHALL hold the accumulator, counter and phase.
REQ-029 In OUT, `out_valid` SHALL be 1 and `out_data` SHALL equal the accumulator.
  - Both SHALL hold stable until `out_ready`=1, then the FSM goes to IDLE.
REQ-030 `out_data` SHALL be 0 whenever `out_valid`=0.
REQ-031 `abort`=1 in any state SHALL, on the next edge:
  - force IDLE;
  - clear the accumulator, counter and phase;
  - drop any pending result.
REQ-032 `abort` SHALL take priority over `start`, beat acceptance and `out_ready`.
REQ-033 If `start` and `abort` are both 1 in IDLE, the block SHALL remain in IDLE.

Reset
REQ-034 While `rst_n`=0, the block SHALL asynchronously force:
  - state IDLE;
  - accumulator, counter, phase and latched mode/len all 0;
  - `in_ready`, `out_valid` and `busy` 0;
  - all `sum_signal` outputs 0;
  - `previous_sum` and `out_data` 0.
REQ-035 Reset asserted in the middle of a job SHALL discard the job.
  - The first `start` after reset release SHALL behave as from power-up.

Verification
REQ-036 The bench SHALL cover mode 01 with `len`=3, `in_valid` held 1, and the adder model returning `previous_sum`+5.
  - Required: exactly 3 beats accepted, `out_valid` one cycle later, `out_data`=15.
REQ-037 The bench SHALL cover mode 11 with `len`=2, for 4 beats.
  - Required: `sum_signal` sequence {0,1,1,2}, {1,2,2,3}, {0,1,1,2}, {1,2,2,3}.
  - Required: OUT entered after the 4th beat.
REQ-038 The bench SHALL cover `out_ready` held 0 for 5 cycles in OUT.
  - Required: `out_valid` and `out_data` stable throughout; IDLE on the cycle after `out_ready`=1.
REQ-039 The bench SHALL cover `len`=0 in mode 10.
  - Required: one beat with {0,1,1,2} accepted, then OUT.
REQ-040 The bench SHALL cover the accumulator wrap.
  - Stimulus: accumulator at 20'hFFFFE, adder model returning `previous_sum`+3.
  - Required: `out_data`=20'h00001.
REQ-041 The bench SHALL cover `abort` mid-RUN, and `rst_n` low mid-RUN, followed by a new `start`.
  - Required: IDLE and `previous_sum`=0 within one edge; the new job result is independent of the aborted job.

Source files
------------

// File: rtl/pe_seq_ctrl.sv
// pe_seq_ctrl: sequences dot-product beats through a PE adder,
// tracks elements/phases and presents the accumulated result.
module pe_seq_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic [7:0]  len,
  input  logic        abort,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [19:0] pe_sum,
  output logic [1:0]  sum_signal_1,
  output logic [1:0]  sum_signal_2,
  output logic [1:0]  sum_signal_3,
  output logic [1:0]  sum_signal_4,
  output logic [19:0] previous_sum,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [19:0] out_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [19:0] acc;
  logic [7:0]  cnt;
  logic [7:0]  len_q;
  logic [1:0]  mode_q;
  logic        phase;
  logic        accept;
  logic        elem_done;
  logic        last;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next state, handshake and shift-code decode
  always_comb begin
    state_nxt    = state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = (state != IDLE);
    accept       = 1'b0;
    last         = 1'b0;
    sum_signal_1 = 2'd0;
    sum_signal_2 = 2'd0;
    sum_signal_3 = 2'd0;
    sum_signal_4 = 2'd0;
    elem_done    = (mode_q != 2'b11) || phase;
    unique case (1'b1)
      (state == IDLE): begin
        if (start) state_nxt = RUN;
      end
      (state == RUN): begin
        in_ready = 1'b1;
        accept   = in_valid;
        last     = accept && elem_done &&
                   (({1'b0, cnt} + 9'd1) == {1'b0, len_q});
        if (mode_q == 2'b10 ||
            (mode_q == 2'b11 && !phase)) begin
          sum_signal_2 = 2'd1;
          sum_signal_3 = 2'd1;
          sum_signal_4 = 2'd2;
        end else if (mode_q == 2'b11) begin
          sum_signal_1 = 2'd1;
          sum_signal_2 = 2'd2;
          sum_signal_3 = 2'd2;
          sum_signal_4 = 2'd3;
        end
        if (last) state_nxt = OUT;
      end
      (state == OUT): begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
    previous_sum = acc;
    out_data     = out_valid ? acc : 20'd0;
  end

  // accumulator, element counter, phase and job parameters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= 20'd0;
      cnt    <= 8'd0;
      phase  <= 1'b0;
      mode_q <= 2'd0;
      len_q  <= 8'd0;
    end else if (abort) begin
      acc   <= 20'd0;
      cnt   <= 8'd0;
      phase <= 1'b0;
    end else if (state == IDLE && start) begin
      mode_q <= mode;
      len_q  <= (len == 8'd0) ? 8'd1 : len;
      acc    <= 20'd0;
      cnt    <= 8'd0;
      phase  <= 1'b0;
    end else if (accept) begin
      acc <= pe_sum;
      if (mode_q == 2'b11) phase <= ~phase;
      if (elem_done) cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// tb_pe_seq_ctrl: directed jobs with a scoreboard of expected
// shift codes per accepted beat and expected results per output.
module tb_pe_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  mode;
  logic [7:0]  len;
  logic        abort;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] pe_sum;
  logic [1:0]  ss1, ss2, ss3, ss4;
  logic [19:0] previous_sum;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] out_data;
  logic        busy;
  logic [19:0] add_k;

  int errors = 0;
  int checks = 0;
  int beat_cnt = 0;

  logic [7:0]  sq[$];
  logic [19:0] rq[$];

  localparam logic [7:0] S0 = 8'h00;
  localparam logic [7:0] SA = 8'h16;
  localparam logic [7:0] SB = 8'h6B;

  pe_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .len(len), .abort(abort), .in_valid(in_valid),
    .in_ready(in_ready), .pe_sum(pe_sum),
    .sum_signal_1(ss1), .sum_signal_2(ss2),
    .sum_signal_3(ss3), .sum_signal_4(ss4),
    .previous_sum(previous_sum), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // adder model: previous_sum plus a per-beat increment
  assign pe_sum = previous_sum + add_k;

  function automatic void chk(string name, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // monitor: pops expectations whenever the DUT presents traffic
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) begin
        beat_cnt++;
        if (sq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL shift_unexpected: got %0h expected none",
                   {ss1, ss2, ss3, ss4});
        end else begin
          chk("shift", {24'd0, ss1, ss2, ss3, ss4}, {24'd0, sq.pop_front()});
        end
      end
      if (out_valid && out_ready) begin
        if (rq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL result_unexpected: got %0h expected none",
                   out_data);
        end else begin
          chk("result", {12'd0, out_data}, {12'd0, rq.pop_front()});
        end
      end
      if (!out_valid) chk("out_data_zero", {12'd0, out_data}, 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [1:0] m, input logic [7:0] l);
    start = 1'b1;
    mode  = m;
    len   = l;
    tick();
    start = 1'b0;
    beat_cnt = 0;
  endtask

  // bounded wait for the result, then handshake it out
  task automatic drain(input string name);
    int n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({name, "_out_valid"}, {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({name, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 2'd0; len = 8'd0;
    abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    add_k = 20'd0;
    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_prev", {12'd0, previous_sum}, 32'd0);
    chk("rst_shift", {24'd0, ss1, ss2, ss3, ss4}, 32'd0);
    rst_n = 1'b1;
    tick();

    // mode 01, len 3, +5 per beat
    add_k = 20'd5;
    repeat (3) sq.push_back(S0);
    rq.push_back(20'd15);
    start_job(2'b01, 8'd3);
    chk("m01_in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    tick();
    tick();
    chk("m01_not_done", {31'd0, out_valid}, 32'd0);
    tick();
    in_valid = 1'b0;
    chk("m01_latency", {31'd0, out_valid}, 32'd1);
    chk("m01_data", {12'd0, out_data}, 32'd15);
    chk("m01_beats", beat_cnt, 32'd3);
    chk("m01_in_ready_out", {31'd0, in_ready}, 32'd0);
    drain("m01");

    // mode 11, len 2, four beats; then hold out_ready low
    add_k = 20'd1;
    sq.push_back(SA); sq.push_back(SB);
    sq.push_back(SA); sq.push_back(SB);
    rq.push_back(20'd4);
    start_job(2'b11, 8'd2);
    in_valid = 1'b1;
    repeat (3) tick();
    chk("m11_not_done", {31'd0, out_valid}, 32'd0);
    tick();
    in_valid = 1'b0;
    chk("m11_out", {31'd0, out_valid}, 32'd1);
    chk("m11_beats", beat_cnt, 32'd4);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_data", {12'd0, out_data}, 32'd4);
      tick();
    end
    drain("m11");

    // mode 10 with len 0, idle cycles before the beat
    add_k = 20'd7;
    sq.push_back(SA);
    rq.push_back(20'd7);
    start_job(2'b10, 8'd0);
    tick();
    tick();
    chk("gap_prev", {12'd0, previous_sum}, 32'd0);
    chk("gap_busy", {31'd0, busy}, 32'd1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("len0_out", {31'd0, out_valid}, 32'd1);
    chk("len0_beats", beat_cnt, 32'd1);
    drain("len0");

    // accumulator wrap
    sq.push_back(S0); sq.push_back(S0);
    rq.push_back(20'h00001);
    start_job(2'b00, 8'd2);
    add_k = 20'hFFFFE;
    in_valid = 1'b1;
    tick();
    chk("wrap_pre", {12'd0, previous_sum}, 32'h000FFFFE);
    add_k = 20'd3;
    tick();
    in_valid = 1'b0;
    chk("wrap_data", {12'd0, out_data}, 32'h00000001);
    drain("wrap");

    // abort mid-RUN, then a fresh job
    add_k = 20'd9;
    sq.push_back(S0); sq.push_back(S0);
    start_job(2'b01, 8'd4);
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    chk("abort_pre", {12'd0, previous_sum}, 32'd18);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle", {31'd0, busy}, 32'd0);
    chk("abort_prev", {12'd0, previous_sum}, 32'd0);
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", {31'd0, busy}, 32'd0);
    add_k = 20'd2;
    sq.push_back(S0);
    rq.push_back(20'd2);
    start_job(2'b01, 8'd1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    drain("post_abort");

    // abort while a result is pending
    add_k = 20'd3;
    sq.push_back(S0);
    start_job(2'b00, 8'd1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("pend_out", {31'd0, out_valid}, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("pend_drop", {31'd0, out_valid}, 32'd0);
    chk("pend_prev", {12'd0, previous_sum}, 32'd0);

    // reset mid-RUN, then mode 11 from power-up state
    add_k = 20'd4;
    sq.push_back(SA);
    start_job(2'b11, 8'd3);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_prev", {12'd0, previous_sum}, 32'd0);
    chk("rstmid_shift", {24'd0, ss1, ss2, ss3, ss4}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    add_k = 20'd6;
    sq.push_back(SA); sq.push_back(SB);
    rq.push_back(20'd12);
    start_job(2'b11, 8'd1);
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    chk("rstnew_beats", beat_cnt, 32'd2);
    drain("rstnew");

    tick();
    chk("shift_q_empty", sq.size(), 32'd0);
    chk("result_q_empty", rq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
